// File: rtl/cs_result_fifo.sv
// Result capture FIFO: holds upstream results once the averaging window is
// full, hands them to a ready/valid consumer, and records dropped samples.
module cs_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WARM  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               y_in,
    input  logic                     cap_en,
    output logic [9:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     warm,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WARM < 1) ? 1 : $clog2(WARM + 1);

    localparam logic [WW-1:0] WARM_MAX  = WW'(WARM);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [WW-1:0] warm_cnt_q, warm_cnt_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          ovf_q,      ovf_d;
    logic [7:0]    drop_q,     drop_d;
    logic [9:0]    mem_q [DEPTH];

    logic warm_now;
    logic full;
    logic push_try;
    logic pop;
    logic push_ok;
    logic drop;

    // Handshake decode for this edge
    always_comb begin
        warm_now = (warm_cnt_q == WARM_MAX);
        full     = (count_q == COUNT_MAX);
        push_try = warm_now && cap_en;
        pop      = (count_q != '0) && out_ready;
        // A full FIFO still accepts a sample when the head leaves on the same edge
        push_ok  = push_try && (!full || pop);
        drop     = push_try && full && !pop;
    end

    // Next-state for warm-up counter, pointers, occupancy and drop tracking
    always_comb begin
        warm_cnt_d = warm_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;

        if (!warm_now) begin
            warm_cnt_d = warm_cnt_q + WW'(1);
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= y_in;
        end
    end

    // Output drive straight from registered state (no bypass path)
    always_comb begin
        out_data  = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        count     = count_q;
        warm      = warm_now;
        overflow  = ovf_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_cs_result_fifo.sv
// Directed bench for cs_result_fifo: vector table plus hand-written sequences.
module tb_cs_result_fifo;

    logic       clk;
    logic       reset;
    logic [9:0] y_in;
    logic       cap_en;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       warm;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_vec;
    int n_err;

    cs_result_fifo #(.DEPTH(4), .WARM(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .cap_en    (cap_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .warm      (warm),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [9:0] y;
        logic       cap;
        logic       rdy;
        logic       ev;
        logic       cd;
        logic [9:0] ed;
        logic [2:0] ec;
        logic       ew;
        logic       eo;
        logic [7:0] edc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input int y, input logic cap, input logic rdy,
                                input logic ev, input logic cd, input int ed, input int ec,
                                input logic ew, input logic eo, input int edc);
        vec_t v;
        v.rst = rst; v.y = 10'(y); v.cap = cap; v.rdy = rdy;
        v.ev = ev; v.cd = cd; v.ed = 10'(ed); v.ec = 3'(ec);
        v.ew = ew; v.eo = eo; v.edc = 8'(edc);
        return v;
    endfunction

    task automatic step(input logic rst, input int y, input logic cap, input logic rdy);
        reset     = rst;
        y_in      = 10'(y);
        cap_en    = cap;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic ev, input logic cd, input logic [9:0] ed,
                         input logic [2:0] ec, input logic ew, input logic eo, input logic [7:0] edc);
        n_vec++;
        if (out_valid !== ev) begin
            n_err++; $display("FAIL %s out_valid got %0b want %0b", nm, out_valid, ev);
        end
        if (cd && out_data !== ed) begin
            n_err++; $display("FAIL %s out_data got %0d want %0d", nm, out_data, ed);
        end
        if (count !== ec) begin
            n_err++; $display("FAIL %s count got %0d want %0d", nm, count, ec);
        end
        if (warm !== ew) begin
            n_err++; $display("FAIL %s warm got %0b want %0b", nm, warm, ew);
        end
        if (overflow !== eo) begin
            n_err++; $display("FAIL %s overflow got %0b want %0b", nm, overflow, eo);
        end
        if (drop_cnt !== edc) begin
            n_err++; $display("FAIL %s drop_cnt got %0d want %0d", nm, drop_cnt, edc);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; y_in = '0; cap_en = 1'b0; out_ready = 1'b0;

        // rst y cap rdy | valid chkdata data count warm ovf drop
        tbl.push_back(mk(1, 0,   0, 0, 0, 1, 0,   0, 0, 0, 0));   // reset state
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 100, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // warm-up edges 1..8
        tbl.push_back(mk(0, 100, 1, 1, 0, 0, 0,   0, 1, 0, 0));   // edge 9: warm, no push yet
        tbl.push_back(mk(0, 100, 1, 1, 1, 1, 100, 1, 1, 0, 0));   // edge 10: first push
        tbl.push_back(mk(0, 0,   0, 1, 0, 0, 0,   0, 1, 0, 0));   // pop to empty
        tbl.push_back(mk(0, 0,   0, 1, 0, 0, 0,   0, 1, 0, 0));   // ready while empty
        tbl.push_back(mk(0, 1,   1, 0, 1, 1, 1,   1, 1, 0, 0));
        tbl.push_back(mk(0, 2,   1, 0, 1, 1, 1,   2, 1, 0, 0));
        tbl.push_back(mk(0, 3,   1, 0, 1, 1, 1,   3, 1, 0, 0));
        tbl.push_back(mk(0, 4,   1, 0, 1, 1, 1,   4, 1, 0, 0));   // full
        tbl.push_back(mk(0, 5,   1, 0, 1, 1, 1,   4, 1, 1, 1));   // dropped
        tbl.push_back(mk(0, 7,   1, 1, 1, 1, 2,   4, 1, 1, 1));   // push+pop while full
        tbl.push_back(mk(0, 0,   0, 1, 1, 1, 3,   3, 1, 1, 1));
        tbl.push_back(mk(0, 0,   0, 1, 1, 1, 4,   2, 1, 1, 1));
        tbl.push_back(mk(0, 0,   0, 1, 1, 1, 7,   1, 1, 1, 1));
        tbl.push_back(mk(0, 0,   0, 1, 0, 0, 0,   0, 1, 1, 1));

        foreach (tbl[i]) begin
            step(tbl[i].rst, int'(tbl[i].y), tbl[i].cap, tbl[i].rdy);
            check($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].cd, tbl[i].ed, tbl[i].ec,
                  tbl[i].ew, tbl[i].eo, tbl[i].edc);
        end

        // Drop counter saturation with contents preserved
        step(0, 10, 1, 0);
        step(0, 20, 1, 0);
        step(0, 30, 1, 0);
        step(0, 40, 1, 0);
        check("fill4", 1, 1, 10, 4, 1, 1, 1);
        for (int k = 1; k <= 300; k++) begin
            step(0, 99, 1, 0);
            if (k == 254) check("sat_reach", 1, 1, 10, 4, 1, 1, 255);
        end
        check("sat_hold", 1, 1, 10, 4, 1, 1, 255);
        step(0, 0, 0, 1); check("drain20", 1, 1, 20, 3, 1, 1, 255);
        step(0, 0, 0, 1); check("drain30", 1, 1, 30, 2, 1, 1, 255);
        step(0, 0, 0, 1); check("drain40", 1, 1, 40, 1, 1, 1, 255);
        step(0, 0, 0, 1); check("drain_empty", 0, 0, 0, 0, 1, 1, 255);

        // Mid-operation reset overrides simultaneous push/pop and restarts warm-up
        step(0, 5, 1, 0);
        step(0, 6, 1, 0);
        step(0, 7, 1, 0);
        check("count3", 1, 1, 5, 3, 1, 1, 255);
        step(1, 9, 1, 1);
        check("mid_reset", 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step(0, 55, 1, 0);
            check($sformatf("rewarm%0d", k), 0, 0, 0, 0, (k == 9), 0, 0);
        end
        step(0, 55, 1, 0);
        check("rewarm_push", 1, 1, 55, 1, 1, 0, 0);

        // Capture disabled: warm-up proceeds, nothing is pushed
        step(1, 0, 0, 1);
        for (int k = 1; k <= 29; k++) begin
            step(0, 123, 0, 1);
            if (k == 9) check("capoff_warm", 0, 0, 0, 0, 1, 0, 0);
        end
        check("capoff_20", 0, 0, 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cs_result_fifo.md
CS_RESULT_FIFO -- requirements
Module: cs_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, >= 2).
REQ-002 The block SHALL have parameter WARM, default 9, number of input samples needed to fill the upstream averaging window.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port y_in, input, 10 bits, upstream computed result, presented every cycle.
REQ-006 The block SHALL have port cap_en, input, 1 bit, capture enable for y_in.
REQ-007 The block SHALL have port out_data, output, 10 bits, FIFO head entry.
REQ-008 The block SHALL have port out_valid, output, 1 bit, high when FIFO is non-empty.
REQ-009 The block SHALL have port out_ready, input, 1 bit, consumer accepts out_data when high with out_valid.
REQ-010 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy, 0..DEPTH.
REQ-011 The block SHALL have port warm, output, 1 bit, high once the upstream window is full.
REQ-012 The block SHALL have port overflow, output, 1 bit, sticky flag set on any dropped sample.
REQ-013 The block SHALL have port drop_cnt, output, 8 bits, saturating count of dropped samples.

Function
REQ-014 A warm-up counter SHALL increment on every non-reset rising edge, saturating at WARM. warm SHALL equal (counter == WARM).
REQ-015 A push attempt SHALL occur on a rising edge where warm==1 and cap_en==1, sampling y_in at that edge.
REQ-016 With DEPTH=4 and WARM=9, the first push attempt after reset release SHALL occur on the 10th rising edge.
REQ-017 A pop SHALL occur on a rising edge where out_valid==1 and out_ready==1.
REQ-018 A push attempt SHALL write y_in at the tail if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
REQ-019 A push attempt with count==DEPTH and no pop SHALL discard y_in, set overflow, and increment drop_cnt (saturating at 255).
REQ-020 A push and a pop on the same edge SHALL leave count unchanged, advance the head, and write the tail.
REQ-021 A pop without a push SHALL decrement count. A push without a pop SHALL increment count.
REQ-022 Latency from an accepted push into an empty FIFO to out_valid==1 with out_data==sampled y_in SHALL be one edge; there is no bypass.
REQ-023 out_data SHALL hold stable while out_valid==1 and out_ready==0. out_data is don't-care when out_valid==0.
REQ-024 out_valid SHALL equal (count != 0). out_ready while out_valid==0 SHALL have no effect.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. Entries SHALL leave in push order.
REQ-026 overflow SHALL remain set until reset. drop_cnt SHALL hold at 255 once reached.
REQ-027 cap_en==0 SHALL suppress pushes only; the warm-up counter and pops continue.

Reset
REQ-028 On a rising edge with reset==1: warm-up counter=0, pointers=0, count=0, out_valid=0, warm=0, overflow=0, drop_cnt=0, out_data=0.
REQ-029 Reset SHALL override any simultaneous push or pop.
REQ-030 Reset asserted mid-operation SHALL flush all entries and restart warm-up, requiring WARM+1 edges again before the first push.

Verification
REQ-031 Reset, then y_in=100, cap_en=1, out_ready=1 -> out_valid=0 through edge 9; after edge 10 out_valid=1, out_data=100, warm=1.
REQ-032 After warm-up, out_ready=0, y_in=1,2,3,4,5 on successive edges -> count=4 after the 4th, out_data=1; 5th edge sets overflow=1, drop_cnt=1, count=4.
REQ-033 FIFO full (1,2,3,4), out_ready=1, y_in=7 -> count stays 4, out_data=2 next, overflow unchanged; a subsequent drain yields 2,3,4,7.
REQ-034 FIFO full, out_ready=0, 300 push attempts -> drop_cnt=255, overflow=1, contents unchanged.
REQ-035 count=3, reset for one edge -> count=0, out_valid=0, overflow=0; with cap_en=1 the next push occurs on the 10th edge after release.
REQ-036 After warm-up, cap_en=0 for 20 edges -> count=0, out_valid=0, drop_cnt=0.
